// File: rtl/note_lane.sv
// note_lane: one rhythm-game lane with note shifting, press judging, saturating score and combo
module note_lane #(
  parameter int DEPTH = 5,
  parameter int SCORE_W = 8,
  parameter int COMBO_W = 6,
  parameter int PTS_PERFECT = 3,
  parameter int PTS_GOOD = 1,
  parameter int PTS_MISS = -1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Step,
  input  logic                      Ren,
  input  logic                      KEY,
  output logic [DEPTH-1:0]          LED,
  output logic signed [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0]        combo,
  output logic                      hit_perfect,
  output logic                      hit_good,
  output logic                      miss
);
  localparam int SW = SCORE_W + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'((2 ** (SCORE_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_S = SW'(-(2 ** (SCORE_W - 1)));
  localparam logic signed [SW-1:0] P_PERF = SW'(PTS_PERFECT);
  localparam logic signed [SW-1:0] P_GOOD = SW'(PTS_GOOD);
  localparam logic signed [SW-1:0] P_MISS = SW'(PTS_MISS);
  localparam logic signed [SW-1:0] Z = SW'(0);
  logic k1, k2, armed, press, perf, good, early, fall;
  logic [DEPTH-1:0] kept, led_n;
  logic signed [SW-1:0] sum;
  logic signed [SCORE_W-1:0] score_n;
  logic [COMBO_W-1:0] combo_n;
  always_comb begin
    press = k2 & ~k1 & armed;
    perf = press & LED[DEPTH-1];
    good = press & ~LED[DEPTH-1] & LED[DEPTH-2];
    early = press & ~perf & ~good;
    kept = LED & ~{perf, good, {(DEPTH-2){1'b0}}};
    fall = Step & kept[DEPTH-1];
    led_n = Step ? {kept[DEPTH-2:0], Ren} : kept;
    sum = SW'(score) + (perf ? P_PERF : Z) + (good ? P_GOOD : Z) + (early ? P_MISS : Z) + (fall ? P_MISS : Z);
    score_n = sum > MAX_S ? MAX_S[SCORE_W-1:0] : sum < MIN_S ? MIN_S[SCORE_W-1:0] : sum[SCORE_W-1:0];
    combo_n = (early | fall) ? '0 : ((perf | good) & ~&combo) ? combo + COMBO_W'(1) : combo;
  end
  always_ff @(posedge Clock)
    if (!Reset) begin
      k1 <= 1'b1;
      k2 <= 1'b1;
      armed <= 1'b0;
      LED <= '0;
      score <= '0;
      combo <= '0;
      hit_perfect <= 1'b0;
      hit_good <= 1'b0;
      miss <= 1'b0;
    end else begin
      k1 <= KEY;
      k2 <= k1;
      armed <= armed | KEY;
      LED <= led_n;
      score <= score_n;
      combo <= combo_n;
      hit_perfect <= perf;
      hit_good <= good;
      miss <= early | fall;
    end
endmodule

// File: tb/tb_note_lane.sv
// tb_note_lane: vector table, corner sequences and randomized run against a lane model
module tb_note_lane;
  localparam int D = 5;
  logic Clock, Reset, Step, Ren, KEY;
  logic [D-1:0] LED;
  logic signed [7:0] score;
  logic [5:0] combo;
  logic hit_perfect, hit_good, miss;
  int checks = 0;
  int errors = 0;
  bit lit[D];
  int m_score, m_combo;
  bit m_hp, m_hg, m_ms, kq0, kq1, seen;
  typedef struct {
    bit rst, step, ren, key;
    logic [D-1:0] led;
    int score, combo;
    logic [2:0] pul;
  } vec_t;
  vec_t vq[$];
  note_lane #(.DEPTH(D), .SCORE_W(8), .COMBO_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .Step(Step), .Ren(Ren), .KEY(KEY),
    .LED(LED), .score(score), .combo(combo),
    .hit_perfect(hit_perfect), .hit_good(hit_good), .miss(miss)
  );
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic model_edge(bit rst, bit step, bit ren, bit key);
    int top, delta;
    bit pr;
    m_hp = 0;
    m_hg = 0;
    m_ms = 0;
    if (!rst) begin
      foreach (lit[i]) lit[i] = 0;
      m_score = 0;
      m_combo = 0;
      kq0 = 1;
      kq1 = 1;
      seen = 0;
      return;
    end
    pr = kq1 && !kq0 && seen;
    delta = 0;
    top = -1;
    for (int i = 0; i < D; i++) if (lit[i]) top = i;
    if (pr) begin
      if (top == D - 1) begin lit[top] = 0; delta += 3; m_hp = 1; end
      else if (top == D - 2) begin lit[top] = 0; delta += 1; m_hg = 1; end
      else begin delta -= 1; m_ms = 1; end
    end
    if (step) begin
      if (lit[D-1]) begin delta -= 1; m_ms = 1; end
      for (int i = D - 1; i > 0; i--) lit[i] = lit[i-1];
      lit[0] = ren;
    end
    if (m_ms) m_combo = 0;
    else if (m_hp || m_hg) m_combo = (m_combo < 63) ? m_combo + 1 : 63;
    m_score += delta;
    if (m_score > 127) m_score = 127;
    if (m_score < -128) m_score = -128;
    seen = seen | key;
    kq1 = kq0;
    kq0 = key;
  endtask
  function automatic logic [D-1:0] model_led();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = lit[i];
    return v;
  endfunction
  task automatic cycle(bit rst, bit step, bit ren, bit key);
    Reset = rst;
    Step = step;
    Ren = ren;
    KEY = key;
    @(posedge Clock);
    model_edge(rst, step, ren, key);
    #1;
    check("model_led", int'(LED), int'(model_led()));
    check("model_score", int'(score), m_score);
    check("model_combo", int'(combo), m_combo);
    check("model_pulses", int'({hit_perfect, hit_good, miss}), int'({m_hp, m_hg, m_ms}));
  endtask
  task automatic add(bit rst, bit step, bit ren, bit key, logic [D-1:0] led, int sc, int co, logic [2:0] pul);
    vec_t v;
    v.rst = rst; v.step = step; v.ren = ren; v.key = key;
    v.led = led; v.score = sc; v.combo = co; v.pul = pul;
    vq.push_back(v);
  endtask
  initial begin
    Reset = 0; Step = 0; Ren = 0; KEY = 1;
    add(0,0,0,1, 5'b00000, 0,0,3'b000);
    add(0,0,0,1, 5'b00000, 0,0,3'b000);
    add(1,1,1,1, 5'b00001, 0,0,3'b000);
    add(1,1,0,1, 5'b00010, 0,0,3'b000);
    add(1,1,0,1, 5'b00100, 0,0,3'b000);
    add(1,1,0,1, 5'b01000, 0,0,3'b000);
    add(1,1,0,1, 5'b10000, 0,0,3'b000);
    add(1,1,0,1, 5'b00000,-1,0,3'b001);
    add(1,0,0,1, 5'b00000,-1,0,3'b000);
    add(1,1,1,1, 5'b00001,-1,0,3'b000);
    add(1,1,0,1, 5'b00010,-1,0,3'b000);
    add(1,1,0,1, 5'b00100,-1,0,3'b000);
    add(1,1,0,1, 5'b01000,-1,0,3'b000);
    add(1,1,0,1, 5'b10000,-1,0,3'b000);
    add(1,0,0,0, 5'b10000,-1,0,3'b000);
    add(1,0,0,0, 5'b00000, 2,1,3'b100);
    add(1,0,0,0, 5'b00000, 2,1,3'b000);
    add(1,0,0,1, 5'b00000, 2,1,3'b000);
    add(1,1,1,1, 5'b00001, 2,1,3'b000);
    add(1,1,0,1, 5'b00010, 2,1,3'b000);
    add(1,1,0,1, 5'b00100, 2,1,3'b000);
    add(1,1,0,1, 5'b01000, 2,1,3'b000);
    add(1,0,0,0, 5'b01000, 2,1,3'b000);
    add(1,0,0,1, 5'b00000, 3,2,3'b010);
    add(1,1,1,1, 5'b00001, 3,2,3'b000);
    add(1,1,0,1, 5'b00010, 3,2,3'b000);
    add(1,0,0,0, 5'b00010, 3,2,3'b000);
    add(1,0,0,1, 5'b00010, 2,0,3'b001);
    add(1,0,0,1, 5'b00010, 2,0,3'b000);
    add(1,1,0,1, 5'b00100, 2,0,3'b000);
    add(1,1,0,1, 5'b01000, 2,0,3'b000);
    add(1,1,0,1, 5'b10000, 2,0,3'b000);
    add(1,0,0,0, 5'b10000, 2,0,3'b000);
    add(1,1,0,1, 5'b00000, 5,1,3'b100);
    add(1,0,0,1, 5'b00000, 5,1,3'b000);
    add(1,0,0,0, 5'b00000, 5,1,3'b000);
    add(1,1,0,1, 5'b00000, 4,0,3'b001);
    add(1,0,0,1, 5'b00000, 4,0,3'b000);
    add(1,1,1,1, 5'b00001, 4,0,3'b000);
    add(1,1,1,0, 5'b00011, 4,0,3'b000);
    add(0,1,1,0, 5'b00000, 0,0,3'b000);
    add(1,0,0,0, 5'b00000, 0,0,3'b000);
    add(1,0,0,0, 5'b00000, 0,0,3'b000);
    add(1,0,0,1, 5'b00000, 0,0,3'b000);
    add(1,0,0,0, 5'b00000, 0,0,3'b000);
    add(1,0,0,1, 5'b00000,-1,0,3'b001);
    foreach (vq[i]) begin
      cycle(vq[i].rst, vq[i].step, vq[i].ren, vq[i].key);
      check($sformatf("vec%0d_led", i), int'(LED), int'(vq[i].led));
      check($sformatf("vec%0d_score", i), int'(score), vq[i].score);
      check($sformatf("vec%0d_combo", i), int'(combo), vq[i].combo);
      check($sformatf("vec%0d_pulses", i), int'({hit_perfect, hit_good, miss}), int'(vq[i].pul));
    end
    cycle(0,0,0,1);
    cycle(0,0,0,1);
    for (int n = 0; n < 65; n++) begin
      cycle(1,1,1,1);
      for (int s = 0; s < 4; s++) cycle(1,1,0,1);
      cycle(1,0,0,0);
      cycle(1,0,0,1);
      check("perfect_pulse", int'(hit_perfect), 1);
      if (n == 49) begin
        check("sat_high_score", int'(score), 127);
        check("combo_50", int'(combo), 50);
      end
    end
    check("combo_sat", int'(combo), 63);
    cycle(0,0,0,1);
    cycle(1,0,0,1);
    for (int n = 0; n < 200; n++) begin
      cycle(1,0,0,0);
      cycle(1,0,0,1);
    end
    check("sat_low_score", int'(score), -128);
    check("sat_low_combo", int'(combo), 0);
    cycle(0,0,0,1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) KEY = ~KEY;
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, KEY);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
